seven_seg_display_ctrl: RTL

//  Display scheduler in front of basys3_7seg_driver. Shares the 4-digit display between two sources:
//   - a continuous BCD value (e.g. stopwatch count);
//   - a one-shot message requester (e.g. "done", scores) via req/ack handshake.

---
 rtl/seven_seg_display_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_display_ctrl.sv
// Display scheduler for a 4-digit seven-segment driver: arbitrates between a live BCD value and
// one-shot req/ack messages, and adds leading-zero blanking and blinking on the value path.
module seven_seg_display_ctrl #(
    parameter int HOLD_CYCLES = 2000,
    parameter int BLINK_HALF  = 250
) (
    input  logic        clk_1k_i,
    input  logic        rst_i,
    input  logic [15:0] value_i,
    input  logic        value_valid_i,
    input  logic        lzb_en_i,
    input  logic        blink_i,
    input  logic        msg_req_i,
    input  logic [15:0] msg_i,
    input  logic [3:0]  msg_mask_i,
    output logic        msg_ack_o,
    output logic        msg_busy_o,
    output logic [3:0]  digit0_o,
    output logic [3:0]  digit1_o,
    output logic [3:0]  digit2_o,
    output logic [3:0]  digit3_o,
    output logic        digit0_en_o,
    output logic        digit1_en_o,
    output logic        digit2_en_o,
    output logic        digit3_en_o
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int BW = $clog2(2 * BLINK_HALF);

    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES);
    localparam logic [BW-1:0] BLINK_MID  = BW'(BLINK_HALF);
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_HALF - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VALUE,
        ST_MSG
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [15:0]   msg_q, msg_d;
    logic [3:0]    mask_q, mask_d;
    logic [15:0]   dig_q, dig_d;
    logic [3:0]    en_q, en_d;
    logic          ack_q, busy_q;
    logic          capture, hold_done;
    logic          lz3, lz2, lz1, blink_off;

    // Output registers are loaded from the next-state view so a decision made in cycle T is
    // visible on the pins in cycle T+1.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block can infer a latch.
        state_d   = state_q;
        hold_d    = hold_q;
        blink_d   = blink_q;
        dig_d     = '0;
        en_d      = 4'b1111;
        capture   = msg_req_i && !ack_q;
        hold_done = (state_q == ST_MSG) && (hold_q <= HW'(1));

        if (capture) begin
            state_d = ST_MSG;
        end else begin
            case (state_q)
                ST_IDLE:  if (value_valid_i) state_d = ST_VALUE;
                ST_VALUE: if (!value_valid_i) state_d = ST_IDLE;
                ST_MSG:   if (hold_done) state_d = value_valid_i ? ST_VALUE : ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end

        if (capture) begin
            hold_d = HOLD_LOAD;
        end else if (state_q == ST_MSG && hold_q != '0) begin
            hold_d = hold_q - HW'(1);
        end

        // Blink phase restarts at zero on each entry to VALUE and freezes elsewhere.
        if (state_d == ST_VALUE) begin
            if (state_q != ST_VALUE)      blink_d = '0;
            else if (blink_q == BLINK_LAST) blink_d = '0;
            else                          blink_d = blink_q + BW'(1);
        end

        msg_d  = capture ? msg_i : msg_q;
        mask_d = capture ? msg_mask_i : mask_q;

        lz3       = lzb_en_i && (value_i[15:12] == 4'h0);
        lz2       = lz3 && (value_i[11:8] == 4'h0);
        lz1       = lz2 && (value_i[7:4] == 4'h0);
        blink_off = blink_i && (blink_d >= BLINK_MID);

        case (state_d)
            ST_VALUE: begin
                dig_d = value_i;
                en_d  = blink_off ? 4'b1111 : {lz3, lz2, lz1, 1'b0};
            end
            ST_MSG: begin
                dig_d = msg_d;
                en_d  = ~mask_d;
            end
            default: begin
                dig_d = '0;
                en_d  = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk_1k_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            blink_q <= '0;
            msg_q   <= '0;
            mask_q  <= '0;
            dig_q   <= '0;
            en_q    <= 4'b1111;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            hold_q  <= hold_d;
            blink_q <= blink_d;
            msg_q   <= msg_d;
            mask_q  <= mask_d;
            dig_q   <= dig_d;
            en_q    <= en_d;
            ack_q   <= capture;
            busy_q  <= (state_d == ST_MSG);
        end
    end

    assign msg_ack_o   = ack_q;
    assign msg_busy_o  = busy_q;
    assign digit0_o    = dig_q[3:0];
    assign digit1_o    = dig_q[7:4];
    assign digit2_o    = dig_q[11:8];
    assign digit3_o    = dig_q[15:12];
    assign digit0_en_o = en_q[0];
    assign digit1_en_o = en_q[1];
    assign digit2_en_o = en_q[2];
    assign digit3_en_o = en_q[3];

endmodule
